// File: rtl/flag_pkg.sv
// Shared constants and types for the RAT status-flag unit.
// Optional build macro FLAG_UNIT_OVF_WRAP_EN selects a circular shadow stack.
package flag_pkg;

  localparam int unsigned FLG_C           = 0;
  localparam int unsigned FLG_Z           = 1;

  localparam int unsigned DEF_NUM_FLAGS   = 2;
  localparam int unsigned DEF_STACK_DEPTH = 4;
  localparam int unsigned DEF_STK_CNT_W   = $clog2(DEF_STACK_DEPTH) + 1;

  typedef logic [DEF_STK_CNT_W-1:0] stk_cnt_t;

endpackage

// File: rtl/flag_shadow_stack.sv
// Interrupt shadow stack: storage, occupancy count, push/pop/swap arbitration.
// FLAG_UNIT_OVF_WRAP_EN: circular storage, push while full overwrites the oldest entry.
module flag_shadow_stack
  import flag_pkg::*;
#(
  parameter int unsigned NUM_FLAGS   = DEF_NUM_FLAGS,
  parameter int unsigned STACK_DEPTH = DEF_STACK_DEPTH,
  localparam int unsigned AW         = $clog2(STACK_DEPTH),
  localparam int unsigned CW         = $clog2(STACK_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [NUM_FLAGS-1:0] push_data,
  output logic [NUM_FLAGS-1:0] top_c,
  output logic [CW-1:0]        cnt,
  output logic                 full,
  output logic                 empty,
  output logic                 push_valid_c,
  output logic                 pop_valid_c,
  output logic                 err_c
);

  logic [NUM_FLAGS-1:0] mem [STACK_DEPTH];
  logic [CW-1:0]        cnt_q, cnt_n;
  logic                 full_q, empty_q;
  logic [AW-1:0]        head_q;
  logic [AW-1:0]        top_addr, wr_addr;
  logic                 we;
`ifdef FLAG_UNIT_OVF_WRAP_EN
  logic [AW-1:0]        head_n;
`endif

  // Entry addresses are relative to the oldest slot; modulo comes from AW truncation.
  assign top_addr = head_q + AW'(cnt_q) - AW'(1);
  assign top_c    = mem[top_addr];

  always_comb begin
    cnt_n        = cnt_q;
    we           = 1'b0;
    wr_addr      = head_q + AW'(cnt_q);
    push_valid_c = 1'b0;
    pop_valid_c  = 1'b0;
    err_c        = 1'b0;
`ifdef FLAG_UNIT_OVF_WRAP_EN
    head_n       = head_q;
`endif
    if (push && pop) begin
      if (empty_q) begin
        we           = 1'b1;
        cnt_n        = cnt_q + CW'(1);
        push_valid_c = 1'b1;
        err_c        = 1'b1;
      end else begin
        // Swap: top entry takes live flags while live flags take the old top.
        we           = 1'b1;
        wr_addr      = top_addr;
        push_valid_c = 1'b1;
        pop_valid_c  = 1'b1;
      end
    end else if (push) begin
      if (!full_q) begin
        we           = 1'b1;
        cnt_n        = cnt_q + CW'(1);
        push_valid_c = 1'b1;
      end else begin
        err_c = 1'b1;
`ifdef FLAG_UNIT_OVF_WRAP_EN
        we           = 1'b1;
        head_n       = head_q + AW'(1);
        push_valid_c = 1'b1;
`endif
      end
    end else if (pop) begin
      if (!empty_q) begin
        cnt_n       = cnt_q - CW'(1);
        pop_valid_c = 1'b1;
      end else begin
        err_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_n;
      full_q  <= (cnt_n == CW'(STACK_DEPTH));
      empty_q <= (cnt_n == '0);
    end
  end

`ifdef FLAG_UNIT_OVF_WRAP_EN
  always_ff @(posedge clk) begin
    if (rst) head_q <= '0;
    else     head_q <= head_n;
  end
`else
  assign head_q = '0;
`endif

  // Contents need no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (we && !rst) mem[wr_addr] <= push_data;
  end

  assign cnt   = cnt_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/flag_unit.sv
// Status-flag register bank with per-bit load/set/clear and interrupt shadow stack.
// FLAG_UNIT_OVF_WRAP_EN is handled inside flag_shadow_stack.
module flag_unit
  import flag_pkg::*;
#(
  parameter int unsigned          NUM_FLAGS     = DEF_NUM_FLAGS,
  parameter int unsigned          STACK_DEPTH   = DEF_STACK_DEPTH,
  parameter logic [NUM_FLAGS-1:0] PUSH_CLR_MASK = '0
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_FLAGS-1:0]         FLG_LD,
  input  logic [NUM_FLAGS-1:0]         FLG_SET,
  input  logic [NUM_FLAGS-1:0]         FLG_CLR,
  input  logic [NUM_FLAGS-1:0]         FLG_DIN,
  input  logic                         SHAD_PUSH,
  input  logic                         SHAD_POP,
  input  logic                         ERR_CLR,
  output logic [NUM_FLAGS-1:0]         FLAGS,
  output logic [$clog2(STACK_DEPTH):0] STK_CNT,
  output logic                         STK_FULL,
  output logic                         STK_EMPTY,
  output logic                         STK_ERR
);

  logic [NUM_FLAGS-1:0] flags_q, flags_n;
  logic [NUM_FLAGS-1:0] top_c;
  logic                 push_valid_c, pop_valid_c, stk_err_c;
  logic                 err_q, err_n;

  flag_shadow_stack #(
    .NUM_FLAGS   (NUM_FLAGS),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk          (CLK),
    .rst          (RST),
    .push         (SHAD_PUSH),
    .pop          (SHAD_POP),
    .push_data    (flags_q),
    .top_c        (top_c),
    .cnt          (STK_CNT),
    .full         (STK_FULL),
    .empty        (STK_EMPTY),
    .push_valid_c (push_valid_c),
    .pop_valid_c  (pop_valid_c),
    .err_c        (stk_err_c)
  );

  // Per-bit priority: clear, set, restore, push mask, load, hold.
  always_comb begin
    flags_n = flags_q;
    err_n   = err_q;
    for (int i = 0; i < NUM_FLAGS; i++) begin
      if (FLG_CLR[i])                              flags_n[i] = 1'b0;
      else if (FLG_SET[i])                         flags_n[i] = 1'b1;
      else if (pop_valid_c)                        flags_n[i] = top_c[i];
      else if (push_valid_c && PUSH_CLR_MASK[i])   flags_n[i] = 1'b0;
      else if (FLG_LD[i])                          flags_n[i] = FLG_DIN[i];
    end
    if (stk_err_c)    err_n = 1'b1;
    else if (ERR_CLR) err_n = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_n;
      err_q   <= err_n;
    end
  end

  assign FLAGS   = flags_q;
  assign STK_ERR = err_q;

endmodule

// File: tb/tb_flag_unit.sv
// Directed bench for flag_unit: default instance plus one with PUSH_CLR_MASK=2'b10.
module tb_flag_unit;
  import flag_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] flg_ld = '0, flg_set = '0, flg_clr = '0, flg_din = '0;
  logic       shad_push = 1'b0, shad_pop = 1'b0, err_clr = 1'b0;

  logic [1:0] flags, m_flags;
  stk_cnt_t   stk_cnt, m_cnt;
  logic       stk_full, stk_empty, stk_err;
  logic       m_full, m_empty, m_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  flag_unit u_dut (
    .CLK(clk), .RST(rst), .FLG_LD(flg_ld), .FLG_SET(flg_set), .FLG_CLR(flg_clr),
    .FLG_DIN(flg_din), .SHAD_PUSH(shad_push), .SHAD_POP(shad_pop), .ERR_CLR(err_clr),
    .FLAGS(flags), .STK_CNT(stk_cnt), .STK_FULL(stk_full), .STK_EMPTY(stk_empty),
    .STK_ERR(stk_err)
  );

  flag_unit #(.PUSH_CLR_MASK(2'b10)) u_msk (
    .CLK(clk), .RST(rst), .FLG_LD(flg_ld), .FLG_SET(flg_set), .FLG_CLR(flg_clr),
    .FLG_DIN(flg_din), .SHAD_PUSH(shad_push), .SHAD_POP(shad_pop), .ERR_CLR(err_clr),
    .FLAGS(m_flags), .STK_CNT(m_cnt), .STK_FULL(m_full), .STK_EMPTY(m_empty),
    .STK_ERR(m_err)
  );

  // Apply one cycle of inputs, clock it, return to idle and stop at the negedge.
  task automatic drive(input logic r, input logic [1:0] ld, input logic [1:0] set,
                       input logic [1:0] clr, input logic [1:0] din,
                       input logic push, input logic pop, input logic eclr);
    rst = r; flg_ld = ld; flg_set = set; flg_clr = clr; flg_din = din;
    shad_push = push; shad_pop = pop; err_clr = eclr;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; flg_ld = '0; flg_set = '0; flg_clr = '0; flg_din = '0;
    shad_push = 1'b0; shad_pop = 1'b0; err_clr = 1'b0;
  endtask

  task automatic test_reset();
    drive(1'b1, 2'b00, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (flags !== 2'b00) begin n_bad++; $display("FAIL rst_flags got=%b want=00", flags); end
    n_cmp++; if (stk_cnt !== 3'd0) begin n_bad++; $display("FAIL rst_cnt got=%0d want=0", stk_cnt); end
    n_cmp++; if (stk_empty !== 1'b1) begin n_bad++; $display("FAIL rst_empty got=%b want=1", stk_empty); end
    n_cmp++; if (stk_full !== 1'b0) begin n_bad++; $display("FAIL rst_full got=%b want=0", stk_full); end
    n_cmp++; if (stk_err !== 1'b0) begin n_bad++; $display("FAIL rst_err got=%b want=0", stk_err); end
  endtask

  task automatic test_priority();
    drive(1'b0, 2'b01, 2'b01, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (flags !== 2'b00) begin n_bad++; $display("FAIL prio_clr got=%b want=00", flags); end
    drive(1'b0, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (flags !== 2'b10) begin n_bad++; $display("FAIL prio_set got=%b want=10", flags); end
    drive(1'b0, 2'b11, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (flags !== 2'b01) begin n_bad++; $display("FAIL prio_ld got=%b want=01", flags); end
  endtask

  task automatic test_nesting();
    logic [1:0] exp_f [3];
    exp_f[0] = 2'b10; exp_f[1] = 2'b01; exp_f[2] = 2'b00;
    drive(1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 2'b11, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 2'b11, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 2'b11, 2'b00, 2'b00, 2'b11, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (flags !== 2'b11) begin n_bad++; $display("FAIL nest_flags got=%b want=11", flags); end
    n_cmp++; if (stk_cnt !== 3'd3) begin n_bad++; $display("FAIL nest_cnt got=%0d want=3", stk_cnt); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
      n_cmp++; if (flags !== exp_f[i]) begin n_bad++; $display("FAIL nest_pop%0d got=%b want=%b", i, flags, exp_f[i]); end
      n_cmp++; if (stk_cnt !== 3'(2 - i)) begin n_bad++; $display("FAIL nest_popcnt%0d got=%0d want=%0d", i, stk_cnt, 2 - i); end
    end
    n_cmp++; if (stk_empty !== 1'b1) begin n_bad++; $display("FAIL nest_empty got=%b want=1", stk_empty); end
    n_cmp++; if (stk_err !== 1'b0) begin n_bad++; $display("FAIL nest_err got=%b want=0", stk_err); end
  endtask

  task automatic test_swap();
    drive(1'b0, 2'b11, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 2'b11, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (flags !== 2'b01 || stk_cnt !== 3'd1) begin n_bad++; $display("FAIL swap_setup got=%b/%0d want=01/1", flags, stk_cnt); end
    drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (flags !== 2'b10) begin n_bad++; $display("FAIL swap_flags got=%b want=10", flags); end
    n_cmp++; if (stk_cnt !== 3'd1) begin n_bad++; $display("FAIL swap_cnt got=%0d want=1", stk_cnt); end
    n_cmp++; if (stk_err !== 1'b0) begin n_bad++; $display("FAIL swap_err got=%b want=0", stk_err); end
    drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (flags !== 2'b01) begin n_bad++; $display("FAIL swap_top got=%b want=01", flags); end
    n_cmp++; if (stk_empty !== 1'b1) begin n_bad++; $display("FAIL swap_empty got=%b want=1", stk_empty); end
  endtask

  task automatic test_overflow();
    logic [1:0] din_seq [5];
    logic [1:0] exp_p [5];
    din_seq[0] = 2'b01; din_seq[1] = 2'b10; din_seq[2] = 2'b11; din_seq[3] = 2'b01; din_seq[4] = 2'b10;
`ifdef FLAG_UNIT_OVF_WRAP_EN
    exp_p[0] = 2'b01; exp_p[1] = 2'b11; exp_p[2] = 2'b10; exp_p[3] = 2'b01; exp_p[4] = 2'b01;
`else
    exp_p[0] = 2'b11; exp_p[1] = 2'b10; exp_p[2] = 2'b01; exp_p[3] = 2'b00; exp_p[4] = 2'b00;
`endif
    drive(1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 2'b11, 2'b00, 2'b00, din_seq[i], 1'b1, 1'b0, 1'b0);
    n_cmp++; if (stk_full !== 1'b1) begin n_bad++; $display("FAIL ovf_full got=%b want=1", stk_full); end
    n_cmp++; if (stk_err !== 1'b1) begin n_bad++; $display("FAIL ovf_err got=%b want=1", stk_err); end
    n_cmp++; if (stk_cnt !== 3'd4) begin n_bad++; $display("FAIL ovf_cnt got=%0d want=4", stk_cnt); end
    n_cmp++; if (flags !== 2'b10) begin n_bad++; $display("FAIL ovf_flags got=%b want=10", flags); end
    drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (stk_err !== 1'b0) begin n_bad++; $display("FAIL errclr got=%b want=0", stk_err); end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
      n_cmp++; if (flags !== exp_p[i]) begin n_bad++; $display("FAIL ovf_pop%0d got=%b want=%b", i, flags, exp_p[i]); end
      if (i == 3) begin
        n_cmp++; if (stk_err !== 1'b0) begin n_bad++; $display("FAIL ovf_pop_err got=%b want=0", stk_err); end
      end
    end
    n_cmp++; if (stk_err !== 1'b1) begin n_bad++; $display("FAIL udf_err got=%b want=1", stk_err); end
    n_cmp++; if (stk_cnt !== 3'd0) begin n_bad++; $display("FAIL udf_cnt got=%0d want=0", stk_cnt); end
    drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
    n_cmp++; if (stk_err !== 1'b1) begin n_bad++; $display("FAIL err_wins got=%b want=1", stk_err); end
    drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1);
    n_cmp++; if (stk_err !== 1'b1 || stk_cnt !== 3'd1) begin n_bad++; $display("FAIL pp_empty got=%b/%0d want=1/1", stk_err, stk_cnt); end
  endtask

  task automatic test_mask();
    drive(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (m_flags !== 2'b01) begin n_bad++; $display("FAIL mask_push got=%b want=01", m_flags); end
    n_cmp++; if (flags !== 2'b11) begin n_bad++; $display("FAIL nomask_push got=%b want=11", flags); end
    n_cmp++; if (m_cnt !== 3'd1) begin n_bad++; $display("FAIL mask_cnt got=%0d want=1", m_cnt); end
    drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (m_flags !== 2'b11) begin n_bad++; $display("FAIL mask_pop got=%b want=11", m_flags); end
    n_cmp++; if (m_empty !== 1'b1 || m_err !== 1'b0) begin n_bad++; $display("FAIL mask_state got=%b/%b want=1/0", m_empty, m_err); end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (stk_cnt !== 3'd2) begin n_bad++; $display("FAIL mid_cnt got=%0d want=2", stk_cnt); end
    drive(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (stk_cnt !== 3'd0 || stk_empty !== 1'b1) begin n_bad++; $display("FAIL mid_rst got=%0d/%b want=0/1", stk_cnt, stk_empty); end
    drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (stk_err !== 1'b1 || flags !== 2'b00) begin n_bad++; $display("FAIL mid_udf got=%b/%b want=1/00", stk_err, flags); end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_nesting();
    test_swap();
    test_overflow();
    test_mask();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
